// File: rtl/lsu_bridge_pkg.sv
// Shared types for the LSU-side memory bridge and its address decoder.
package lsu_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DMEM_ACC  = 3'd1,
    ST_DMEM_CAP  = 3'd2,
    ST_MMIO_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } bridge_state_t;

  typedef enum logic [1:0] {
    REG_DMEM = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational region decode of a byte address into data BRAM, MMIO window or unmapped.
module lsu_addr_decode
  import lsu_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH_D = 10,
  parameter logic [31:0] DMEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
  parameter int          MMIO_BITS    = 16
) (
  input  logic [31:0]             addr,
  output region_t                 region,
  output logic [ADDR_WIDTH_D-1:0] dmem_word,
  output logic [MMIO_BITS-1:0]    mmio_off
);

  logic [31:0] dmem_off_s;
  logic [32:0] dmem_size_s;
  logic        dmem_hit_s;
  logic        mmio_hit_s;

  // Wrapping subtraction makes addresses below the base fail the size compare.
  assign dmem_off_s  = addr - DMEM_BASE;
  assign dmem_size_s = 33'd4 << ADDR_WIDTH_D;
  assign dmem_hit_s  = {1'b0, dmem_off_s} < dmem_size_s;
  assign mmio_hit_s  = addr[31:MMIO_BITS] == MMIO_BASE[31:MMIO_BITS];
  assign dmem_word   = dmem_off_s[ADDR_WIDTH_D+1:2];
  assign mmio_off    = addr[MMIO_BITS-1:0];

  // Region priority: BRAM shadows the MMIO window if they overlap.
  always_comb begin
    region = REG_NONE;
    if (dmem_hit_s) begin
      region = REG_DMEM;
    end else if (mmio_hit_s) begin
      region = REG_MMIO;
    end else begin
      region = REG_NONE;
    end
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Terminates the core's load/store handshake and routes each access to data BRAM,
// the MMIO bus (with timeout) or an error response, recording bus errors.
module lsu_mem_bridge
  import lsu_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH_D = 10,
  parameter logic [31:0] DMEM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
  parameter int          MMIO_BITS    = 16,
  parameter int          TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rready_cpu,
  output logic                    rvalid_cpu,
  input  logic                    wvalid_cpu,
  output logic                    wready_cpu,
  input  logic [3:0]              strb_cpu,
  input  logic [31:0]             addr_cpu,
  input  logic [31:0]             data_cpu_o,
  output logic [31:0]             data_cpu_i,
  output logic                    dmem_en,
  output logic [3:0]              dmem_we,
  output logic [ADDR_WIDTH_D-1:0] dmem_addr,
  output logic [31:0]             dmem_wdata,
  input  logic [31:0]             dmem_rdata,
  output logic                    mmio_req,
  output logic                    mmio_we,
  output logic [3:0]              mmio_strb,
  output logic [MMIO_BITS-1:0]    mmio_addr,
  output logic [31:0]             mmio_wdata,
  input  logic [31:0]             mmio_rdata,
  input  logic                    mmio_ack,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [31:0]             err_addr
);

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  bridge_state_t           state_r, next_s;
  region_t                 region_s;
  logic [ADDR_WIDTH_D-1:0] dmem_word_s;
  logic [MMIO_BITS-1:0]    mmio_off_s;
  logic [31:0]             addr_r, err_addr_s;
  logic                    we_r, req_s, req_we_s, err_s;
  logic [CNT_W-1:0]        cnt_r;

  lsu_addr_decode #(
    .ADDR_WIDTH_D(ADDR_WIDTH_D),
    .DMEM_BASE   (DMEM_BASE),
    .MMIO_BASE   (MMIO_BASE),
    .MMIO_BITS   (MMIO_BITS)
  ) u_decode (
    .addr     (addr_cpu),
    .region   (region_s),
    .dmem_word(dmem_word_s),
    .mmio_off (mmio_off_s)
  );

  // Next-state decode; in IDLE the live request stands in for the latched one.
  always_comb begin
    next_s     = state_r;
    err_s      = 1'b0;
    req_s      = wvalid_cpu | rready_cpu;
    req_we_s   = we_r;
    err_addr_s = addr_r;
    case (state_r)
      ST_IDLE: begin
        req_we_s   = wvalid_cpu;
        err_addr_s = addr_cpu;
        if (req_s) begin
          case (region_s)
            REG_DMEM: next_s = ST_DMEM_ACC;
            REG_MMIO: next_s = ST_MMIO_WAIT;
            default: begin
              next_s = ST_RESP;
              err_s  = 1'b1;
            end
          endcase
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_DMEM_ACC: next_s = we_r ? ST_RESP : ST_DMEM_CAP;
      ST_DMEM_CAP: next_s = ST_RESP;
      ST_MMIO_WAIT: begin
        // A late ack on the final wait cycle still counts as success.
        if (mmio_ack) begin
          next_s = ST_RESP;
        end else if (cnt_r == TIMEOUT_C) begin
          next_s = ST_RESP;
          err_s  = 1'b1;
        end else begin
          next_s = ST_MMIO_WAIT;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, request latches and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= 32'h0000_0000;
      we_r       <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      rvalid_cpu <= 1'b0;
      wready_cpu <= 1'b0;
      data_cpu_i <= 32'h0000_0000;
      dmem_en    <= 1'b0;
      dmem_we    <= 4'b0000;
      dmem_addr  <= {ADDR_WIDTH_D{1'b0}};
      dmem_wdata <= 32'h0000_0000;
      mmio_req   <= 1'b0;
      mmio_we    <= 1'b0;
      mmio_strb  <= 4'b0000;
      mmio_addr  <= {MMIO_BITS{1'b0}};
      mmio_wdata <= 32'h0000_0000;
      bus_err    <= 1'b0;
      err_addr   <= 32'h0000_0000;
    end else begin
      state_r    <= next_s;
      rvalid_cpu <= (next_s == ST_RESP) && !req_we_s;
      wready_cpu <= (next_s == ST_RESP) && req_we_s;
      dmem_en    <= next_s == ST_DMEM_ACC;
      dmem_we    <= ((next_s == ST_DMEM_ACC) && req_we_s) ? strb_cpu : 4'b0000;
      mmio_req   <= next_s == ST_MMIO_WAIT;
      if ((state_r == ST_IDLE) && req_s) begin
        addr_r     <= addr_cpu;
        we_r       <= wvalid_cpu;
        dmem_addr  <= dmem_word_s;
        dmem_wdata <= data_cpu_o;
        mmio_we    <= wvalid_cpu;
        mmio_strb  <= strb_cpu;
        mmio_addr  <= mmio_off_s;
        mmio_wdata <= data_cpu_o;
      end
      // Counter holds the index of the current wait cycle, starting at one.
      if (state_r == ST_MMIO_WAIT) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= CNT_ONE;
      end
      if (state_r == ST_DMEM_CAP) begin
        data_cpu_i <= dmem_rdata;
      end else if ((state_r == ST_MMIO_WAIT) && mmio_ack && !we_r) begin
        data_cpu_i <= mmio_rdata;
      end else if (err_s && !req_we_s) begin
        data_cpu_i <= ERR_RDATA;
      end
      // A new error outranks a simultaneous clear.
      if (err_s) begin
        bus_err  <= 1'b1;
        err_addr <= err_addr_s;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: directed plan items plus randomized traffic
// checked against a transaction-level model of memory, MMIO and error state.
module tb_lsu_mem_bridge;

  localparam int TMO = 255;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rready_cpu = 1'b0, wvalid_cpu = 1'b0, err_clr = 1'b0;
  logic [3:0]  strb_cpu = 4'h0;
  logic [31:0] addr_cpu = 32'h0, data_cpu_o = 32'h0;
  logic        rvalid_cpu, wready_cpu, dmem_en, mmio_req, mmio_we, bus_err;
  logic [31:0] data_cpu_i, dmem_wdata, mmio_wdata, err_addr;
  logic [3:0]  dmem_we, mmio_strb;
  logic [9:0]  dmem_addr;
  logic [15:0] mmio_addr;
  logic [31:0] dmem_rdata = 32'h0, mmio_rdata = 32'h0;
  logic        mmio_ack = 1'b0;

  lsu_mem_bridge #(.ADDR_WIDTH_D(10), .DMEM_BASE(32'h0000_0000), .MMIO_BASE(32'h1000_0000),
                   .MMIO_BITS(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rready_cpu(rready_cpu), .rvalid_cpu(rvalid_cpu),
    .wvalid_cpu(wvalid_cpu), .wready_cpu(wready_cpu), .strb_cpu(strb_cpu),
    .addr_cpu(addr_cpu), .data_cpu_o(data_cpu_o), .data_cpu_i(data_cpu_i),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_strb(mmio_strb),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .mmio_ack(mmio_ack), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hCAFE_F00D;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mfn(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // BRAM model: registered read, byte-enabled write.
  logic [31:0] bram [1024];
  bit          loaded = 1'b0;
  int          d_total = 0;
  logic [9:0]  last_d_addr = 10'h0;
  logic [3:0]  last_d_we = 4'h0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) bram[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (dmem_en) begin
      for (int b = 0; b < 4; b++)
        if (dmem_we[b]) bram[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
      dmem_rdata  <= bram[dmem_addr];
      d_total     <= d_total + 1;
      last_d_addr <= dmem_addr;
      last_d_we   <= dmem_we;
    end
  end

  // MMIO responder: acks on the ack_delay-th request cycle (0 = never), optional stray acks.
  int          ack_delay = 0, m_cnt = 0, m_total = 0;
  bit          spurious = 1'b0;
  logic [15:0] last_m_addr = 16'h0;
  logic        last_m_we = 1'b0;
  logic [3:0]  last_m_strb = 4'h0;
  logic [31:0] last_m_wdata = 32'h0;
  always @(posedge clk) begin
    #1;
    if (mmio_req) begin
      m_cnt++;
      m_total++;
      last_m_addr  = mmio_addr;
      last_m_we    = mmio_we;
      last_m_strb  = mmio_strb;
      last_m_wdata = mmio_wdata;
      mmio_ack     = (m_cnt == ack_delay);
      mmio_rdata   = mfn(mmio_addr);
    end else begin
      m_cnt      = 0;
      mmio_ack   = spurious && ($urandom_range(0, 1) == 1);
      mmio_rdata = $urandom;
    end
  end

  typedef struct {
    bit          is_wr;
    int          region;
    logic [31:0] data;
    int          t_exp;
    bit          bus_err;
    logic [31:0] err_addr;
    logic [9:0]  d_addr;
    logic [3:0]  d_we;
    logic [15:0] m_addr;
    bit          m_we;
    logic [3:0]  m_strb;
    logic [31:0] m_wdata;
    int          m_cycles;
    int          d_base;
    int          m_base;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_rdata = 32'h0, m_err_addr = 32'h0;
  bit          m_bus_err = 1'b0;
  int          last_pulse = -10;

  // Monitor: every completion pulse is matched against the oldest expectation.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && (rvalid_cpu || wready_cpu)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: rvalid=%0b wready=%0b with nothing outstanding",
                 rvalid_cpu, wready_cpu);
      end else begin
        me = q.pop_front();
        chk("pulse_onehot", {31'b0, rvalid_cpu & wready_cpu}, 32'h0);
        chk("direction", {31'b0, wready_cpu}, {31'b0, me.is_wr});
        chk("latency", 32'(cyc), 32'(me.t_exp));
        chk("data_cpu_i", data_cpu_i, me.data);
        chk("bus_err", {31'b0, bus_err}, {31'b0, me.bus_err});
        chk("err_addr", err_addr, me.err_addr);
        chk("dmem_accesses", 32'(d_total - me.d_base), (me.region == 0) ? 32'd1 : 32'd0);
        chk("mmio_req_cycles", 32'(m_total - me.m_base), 32'(me.m_cycles));
        if (me.region == 0) begin
          chk("dmem_addr", {22'b0, last_d_addr}, {22'b0, me.d_addr});
          chk("dmem_we", {28'b0, last_d_we}, {28'b0, me.d_we});
        end
        if (me.region == 1) begin
          chk("mmio_addr", {16'b0, last_m_addr}, {16'b0, me.m_addr});
          chk("mmio_we_strb", {27'b0, last_m_we, last_m_strb}, {27'b0, me.m_we, me.m_strb});
          chk("mmio_wdata", last_m_wdata, me.m_wdata);
        end
      end
    end
  end

  // Issue one access from a negedge, record its expectation, hold until completion.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] data, input int ackn, input bit clr);
    exp_t        e;
    int          t;
    bit          err, got;
    logic [31:0] off;
    logic [9:0]  w;
    t   = (cyc > last_pulse + 1) ? cyc : last_pulse + 1;
    off = addr - 32'h0000_0000;
    w   = off[11:2];
    e.is_wr = wr;
    e.region = (off < 32'h1000) ? 0 : ((addr[31:16] == 16'h1000) ? 1 : 2);
    e.d_addr = w;
    e.d_we = wr ? strb : 4'h0;
    e.m_addr = addr[15:0];
    e.m_we = wr;
    e.m_strb = strb;
    e.m_wdata = data;
    e.m_cycles = 0;
    e.d_base = d_total;
    e.m_base = m_total;
    err = 1'b0;
    case (e.region)
      0: begin
        e.t_exp = t + (wr ? 2 : 3);
        if (wr) begin
          for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
        end else last_rdata = ref_mem[w];
      end
      1: begin
        if (ackn > 0) begin
          e.t_exp = t + 1 + ackn;
          e.m_cycles = ackn;
          if (!wr) last_rdata = mfn(addr[15:0]);
        end else begin
          e.t_exp = t + 1 + TMO;
          e.m_cycles = TMO;
          err = 1'b1;
          if (!wr) last_rdata = 32'h0;
        end
      end
      default: begin
        e.t_exp = t + 1;
        err = 1'b1;
        if (!wr) last_rdata = 32'h0;
      end
    endcase
    e.data = last_rdata;
    if (err) begin
      m_bus_err  = 1'b1;
      m_err_addr = addr;
    end else if (clr) m_bus_err = 1'b0;
    e.bus_err  = m_bus_err;
    e.err_addr = m_err_addr;
    q.push_back(e);
    ack_delay = ackn;
    rready_cpu = rd; wvalid_cpu = wr; addr_cpu = addr; strb_cpu = strb; data_cpu_o = data;
    err_clr = clr;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (rvalid_cpu || wready_cpu) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: addr %08h never completed", addr);
    end
    last_pulse = cyc;
    rready_cpu = 1'b0; wvalid_cpu = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    int          t0, sel, dir;
    logic [31:0] a, r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (4) @(negedge clk);
    chk("rst_ctrl", {18'b0, rvalid_cpu, wready_cpu, dmem_en, dmem_we, mmio_req, mmio_we,
                     mmio_strb, bus_err}, 32'h0);
    chk("rst_data_cpu_i", data_cpu_i, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ctrl", {28'b0, rvalid_cpu, wready_cpu, dmem_en, mmio_req}, 32'h0);
    chk("idle_err", {err_addr[30:0], bus_err}, 32'h0);

    txn(1, 0, 32'h0000_0040, 4'hF, 32'h0, 0, 0);
    txn(0, 1, 32'h0000_0043, 4'b1000, 32'hAB00_0000, 0, 0);
    txn(1, 0, 32'h0000_0040, 4'hF, 32'h0, 0, 0);
    txn(0, 1, 32'h1000_0004, 4'hF, 32'h1234_5678, 5, 0);
    txn(1, 0, 32'h1000_0008, 4'hF, 32'h0, 0, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_bus_err = 1'b0;
    chk("err_clr", {31'b0, bus_err}, 32'h0);
    chk("err_addr_kept", err_addr, 32'h1000_0008);
    txn(1, 0, 32'h0000_1000, 4'hF, 32'h0, 0, 0);
    txn(1, 0, 32'h0000_0FFC, 4'hF, 32'h0, 0, 0);
    txn(0, 1, 32'h2000_0000, 4'hF, 32'hDEAD_BEEF, 0, 1);
    @(negedge clk);
    chk("err_beats_clr", {31'b0, bus_err}, 32'h1);
    txn(1, 1, 32'h0000_0080, 4'b0101, 32'h1122_3344, 0, 0);
    txn(0, 1, 32'h0000_0084, 4'b0000, 32'hFFFF_FFFF, 0, 0);

    // Reset while the read sits in its capture cycle.
    t0 = (cyc > last_pulse + 1) ? cyc : last_pulse + 1;
    rready_cpu = 1'b1; addr_cpu = 32'h0000_0040; strb_cpu = 4'hF;
    for (int i = 0; i < 20 && cyc < t0 + 2; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {18'b0, rvalid_cpu, wready_cpu, dmem_en, dmem_we, mmio_req, mmio_we,
                        mmio_strb, bus_err}, 32'h0);
    chk("midrst_data", data_cpu_i, 32'h0);
    chk("midrst_err_addr", err_addr, 32'h0);
    rready_cpu = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0; m_bus_err = 1'b0; m_err_addr = 32'h0; last_pulse = -10;
    repeat (2) @(negedge clk);
    txn(1, 0, 32'h0000_0040, 4'hF, 32'h0, 0, 0);
    txn(1, 0, 32'h0000_0044, 4'hF, 32'h0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 5);
      r   = $urandom;
      case (sel)
        0, 1: a = 32'($urandom_range(0, 4095));
        2: begin
          case (r[1:0])
            2'd0: a = 32'h0000_0FFC;
            2'd1: a = 32'h0000_0FFF;
            2'd2: a = 32'h0000_1000;
            default: a = 32'hFFFF_FFFC;
          endcase
        end
        3: a = 32'h1000_0000 | (r & 32'h0000_FFFF);
        4: a = 32'h2000_0000 + 32'($urandom_range(0, 255));
        default: a = r[2] ? 32'h1001_0000 : 32'h0FFF_FFFC;
      endcase
      dir = $urandom_range(0, 3);
      spurious = ($urandom_range(0, 1) == 1);
      txn(dir != 2, dir >= 2, a, 4'($urandom_range(0, 15)), $urandom,
          $urandom_range(1, 6), $urandom_range(0, 7) == 0);
    end
    spurious = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
